hwloop_ctrl: RTL and testbench

Zero-overhead hardware-loop controller for the RISC-V core. It holds two nested loop contexts (start address, end address, remaining count) written by the decode stage. It watches the current fetch PC and, when that PC reaches an active loop end, raises `hwloop_taken` and drives `pc_hwloop` with the loop start. `next_pc` consumes these signals via `pcsel == 2` and `pc_hwloop`.

---
 rtl/hwloop_ctrl.sv | 127 ++++++++++++
 tb/tb_hwloop_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hwloop_ctrl.sv
// hwloop_ctrl -- zero-overhead hardware-loop controller.
//
// Holds NUM_LOOPS nested loop contexts (start, inclusive end, remaining
// count). While fetch advances, the controller compares the current PC with
// each active context's end address. Context 0 is the innermost context and
// has the highest priority. When a context with more than one iteration left
// is at its end, the controller redirects fetch to that context's start.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   pc                current fetch PC
//   ena               PC advance enable (0 = fetch stalled)
//   branch_taken      branch/jump redirect this cycle; suppresses loop action
//   cfg_we/cfg_idx    write one loop context
//   cfg_start/end     loop body first/last instruction address
//   cfg_count         iteration count (0 disables the context)
//   hwloop_taken      redirect to pc_hwloop this cycle (combinational)
//   pc_hwloop         loop start address when taken, else 0
//   loop_active       bit i = context i has a nonzero count
//   cfg_err           one-cycle pulse after a rejected configuration write
module hwloop_ctrl #(
    parameter int NUM_LOOPS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc,
    input  logic                 ena,
    input  logic                 branch_taken,
    input  logic                 cfg_we,
    input  logic                 cfg_idx,
    input  logic [31:0]          cfg_start,
    input  logic [31:0]          cfg_end,
    input  logic [31:0]          cfg_count,
    output logic                 hwloop_taken,
    output logic [31:0]          pc_hwloop,
    output logic [NUM_LOOPS-1:0] loop_active,
    output logic                 cfg_err
);

    logic [31:0] start_q [NUM_LOOPS];
    logic [31:0] end_q   [NUM_LOOPS];
    logic [31:0] count_q [NUM_LOOPS];
    logic [31:0] start_d [NUM_LOOPS];
    logic [31:0] end_d   [NUM_LOOPS];
    logic [31:0] count_d [NUM_LOOPS];
    logic        cfg_err_q;
    logic        cfg_err_d;

    logic                 step;
    logic [NUM_LOOPS:0]   eval;     // eval[i]: context i gets to look at pc
    logic [NUM_LOOPS-1:0] at_end;
    logic [NUM_LOOPS-1:0] take;
    logic [NUM_LOOPS-1:0] dec;

    logic cfg_reject;
    logic cfg_accept;

    assign step    = ena & ~branch_taken;
    assign eval[0] = step;

    // Per-context evaluation. A context that jumps blocks every outer
    // context; a context that exits on its final iteration passes the
    // decision outward in the same cycle, so a shared end address gives an
    // inner exit together with an outer jump.
    for (genvar gi = 0; gi < NUM_LOOPS; gi++) begin : g_ctx
        assign loop_active[gi] = (count_q[gi] != 32'd0);
        assign at_end[gi]      = loop_active[gi] && (pc == end_q[gi]);
        assign dec[gi]         = eval[gi] & at_end[gi];
        assign take[gi]        = dec[gi] && (count_q[gi] > 32'd1);
        assign eval[gi+1]      = eval[gi] & ~take[gi];
    end

    assign hwloop_taken = |take;

    always_comb begin
        pc_hwloop = 32'd0;
        for (int i = NUM_LOOPS - 1; i >= 0; i--) begin
            if (take[i]) begin
                pc_hwloop = start_q[i];
            end
        end
    end

    // A nonzero count with an inverted range is rejected; a zero count is
    // always accepted because it only disables the context.
    assign cfg_reject = (cfg_count != 32'd0) && (cfg_end < cfg_start);
    assign cfg_accept = cfg_we & ~cfg_reject;
    assign cfg_err_d  = cfg_we & cfg_reject;

    // Next state: an accepted write to a context overrides that context's
    // same-cycle decrement; other contexts decrement normally.
    always_comb begin
        for (int i = 0; i < NUM_LOOPS; i++) begin
            start_d[i] = start_q[i];
            end_d[i]   = end_q[i];
            count_d[i] = count_q[i];
            if (cfg_accept && (cfg_idx == 1'(i))) begin
                start_d[i] = {cfg_start[31:2], 2'b00};
                end_d[i]   = {cfg_end[31:2], 2'b00};
                count_d[i] = cfg_count;
            end else if (dec[i]) begin
                count_d[i] = count_q[i] - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
                start_q[i] <= 32'd0;
                end_q[i]   <= 32'd0;
                count_q[i] <= 32'd0;
            end
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
                start_q[i] <= start_d[i];
                end_q[i]   <= end_d[i];
                count_q[i] <= count_d[i];
            end
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_hwloop_ctrl.sv
// Directed testbench for hwloop_ctrl. Inputs change 1 time unit after the
// rising edge, outputs are sampled 1 time unit later, well before the next
// rising edge.
module tb_hwloop_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ena;
    logic        branch_taken;
    logic        cfg_we;
    logic        cfg_idx;
    logic [31:0] cfg_start;
    logic [31:0] cfg_end;
    logic [31:0] cfg_count;
    logic        hwloop_taken;
    logic [31:0] pc_hwloop;
    logic [1:0]  loop_active;
    logic        cfg_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_taken  = 0;

    hwloop_ctrl #(.NUM_LOOPS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .ena          (ena),
        .branch_taken (branch_taken),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_start    (cfg_start),
        .cfg_end      (cfg_end),
        .cfg_count    (cfg_count),
        .hwloop_taken (hwloop_taken),
        .pc_hwloop    (pc_hwloop),
        .loop_active  (loop_active),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %-24s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end else begin
            $display("FAIL %-24s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic e, input logic b);
        pc           = p;
        ena          = e;
        branch_taken = b;
        #1;
    endtask

    task automatic set_cfg(input logic we, input logic idx, input logic [31:0] s,
                           input logic [31:0] e, input logic [31:0] c);
        cfg_we    = we;
        cfg_idx   = idx;
        cfg_start = s;
        cfg_end   = e;
        cfg_count = c;
    endtask

    // Write one context during a stalled cycle.
    task automatic write_ctx(input logic idx, input logic [31:0] s,
                             input logic [31:0] e, input logic [31:0] c);
        set_cfg(1'b1, idx, s, e, c);
        drive(32'h0, 1'b0, 1'b0);
        tick();
        set_cfg(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    logic [31:0] nest_exp [4];

    initial begin
        rst = 1'b1;
        set_cfg(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive(32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(32'h0, 1'b1, 1'b0);
        check("reset_taken",  {31'd0, hwloop_taken}, 32'd0);
        check("reset_pc",     pc_hwloop, 32'd0);
        check("reset_active", {30'd0, loop_active}, 32'd0);
        check("reset_err",    {31'd0, cfg_err}, 32'd0);
        tick();

        // Basic loop: count 3 -> two redirects, then fall-through.
        write_ctx(1'b0, 32'h4000_0010, 32'h4000_001C, 32'd3);
        drive(32'h0, 1'b0, 1'b0);
        check("basic_active", {30'd0, loop_active}, 32'd1);
        for (int v = 0; v < 3; v++) begin
            for (int a = 0; a < 3; a++) begin
                drive(32'h4000_0010 + 32'(a * 4), 1'b1, 1'b0);
                if (a == 2) check("basic_body", {31'd0, hwloop_taken}, 32'd0);
                tick();
            end
            drive(32'h4000_001C, 1'b1, 1'b0);
            check("basic_end_taken", {31'd0, hwloop_taken}, (v < 2) ? 32'd1 : 32'd0);
            check("basic_end_pc", pc_hwloop, (v < 2) ? 32'h4000_0010 : 32'd0);
            tick();
        end
        drive(32'h0, 1'b0, 1'b0);
        check("basic_inactive", {30'd0, loop_active}, 32'd0);

        // Nested loops sharing an end address; ctx0 reloaded inside outer body.
        nest_exp[0] = 32'h100;
        nest_exp[1] = 32'h0F8;
        nest_exp[2] = 32'h100;
        nest_exp[3] = 32'h0;
        write_ctx(1'b0, 32'h100, 32'h10C, 32'd2);
        write_ctx(1'b1, 32'h0F8, 32'h10C, 32'd2);
        drive(32'h0, 1'b0, 1'b0);
        check("nest_active", {30'd0, loop_active}, 32'd3);
        n_taken = 0;
        for (int v = 0; v < 4; v++) begin
            drive(32'h10C, 1'b1, 1'b0);
            if (hwloop_taken) n_taken++;
            check("nest_target", pc_hwloop, nest_exp[v]);
            tick();
            if (v == 1) write_ctx(1'b0, 32'h100, 32'h10C, 32'd2);
        end
        drive(32'h0, 1'b0, 1'b0);
        check("nest_taken_cnt", 32'(n_taken), 32'd3);
        check("nest_done", {30'd0, loop_active}, 32'd0);

        // Stall and branch suppression.
        write_ctx(1'b0, 32'h200, 32'h20C, 32'd3);
        for (int s = 0; s < 4; s++) begin
            drive(32'h20C, 1'b0, 1'b0);
            check("stall_taken", {31'd0, hwloop_taken}, 32'd0);
            tick();
        end
        drive(32'h20C, 1'b1, 1'b1);
        check("branch_taken_sup", {31'd0, hwloop_taken}, 32'd0);
        tick();
        check("stall_count", dut.count_q[0], 32'd3);
        drive(32'h20C, 1'b1, 1'b0);
        check("release_taken", {31'd0, hwloop_taken}, 32'd1);
        check("release_pc", pc_hwloop, 32'h200);
        tick();
        drive(32'h0, 1'b0, 1'b0);
        check("release_count", dut.count_q[0], 32'd2);

        // Config write collides with a step on the same context.
        set_cfg(1'b1, 1'b0, 32'h200, 32'h20C, 32'd5);
        drive(32'h20C, 1'b1, 1'b0);
        check("coll_taken", {31'd0, hwloop_taken}, 32'd1);
        tick();
        set_cfg(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive(32'h0, 1'b0, 1'b0);
        check("coll_count", dut.count_q[0], 32'd5);

        // Rejected write: end below start.
        set_cfg(1'b1, 1'b0, 32'h200, 32'h100, 32'd4);
        drive(32'h0, 1'b0, 1'b0);
        check("rej_err_same", {31'd0, cfg_err}, 32'd0);
        tick();
        set_cfg(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive(32'h0, 1'b0, 1'b0);
        check("rej_err_pulse", {31'd0, cfg_err}, 32'd1);
        check("rej_count", dut.count_q[0], 32'd5);
        check("rej_end", dut.end_q[0], 32'h20C);
        tick();
        check("rej_err_clear", {31'd0, cfg_err}, 32'd0);

        // Zero count with inverted range is accepted and disables ctx0.
        write_ctx(1'b0, 32'h200, 32'h100, 32'd0);
        drive(32'h0, 1'b0, 1'b0);
        check("zero_no_err", {31'd0, cfg_err}, 32'd0);
        check("zero_inactive", {30'd0, loop_active}, 32'd0);

        // Reset mid-loop; a config write during reset is ignored.
        write_ctx(1'b0, 32'h300, 32'h30C, 32'd7);
        rst = 1'b1;
        set_cfg(1'b1, 1'b1, 32'h300, 32'h30C, 32'd3);
        drive(32'h30C, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        set_cfg(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive(32'h30C, 1'b1, 1'b0);
        check("rst_active", {30'd0, loop_active}, 32'd0);
        check("rst_taken", {31'd0, hwloop_taken}, 32'd0);
        check("rst_pc", pc_hwloop, 32'd0);
        tick();

        // Misaligned configuration addresses are word-aligned on write.
        write_ctx(1'b0, 32'h4000_0013, 32'h4000_001F, 32'd2);
        check("mis_start", dut.start_q[0], 32'h4000_0010);
        check("mis_end", dut.end_q[0], 32'h4000_001C);
        drive(32'h4000_001C, 1'b1, 1'b0);
        check("mis_taken", {31'd0, hwloop_taken}, 32'd1);
        check("mis_pc", pc_hwloop, 32'h4000_0010);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
